// File: rtl/mux8_rr_scheduler_pkg.sv
// Shared constants and state encoding for the 8-way round-robin mux scheduler.
package mux8_rr_scheduler_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
    sel_onehot      = '0;
    sel_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/mux8_rr_scheduler_pick.sv
// Combinational round-robin search: first set request at or after last+1, wrapping.
module rr_pick8
  import mux8_rr_scheduler_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[last + SEL_W'(i)]) begin
        idx = last + SEL_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin owner scheduler driving the select lines of an external 8:1 mux.
// Optional forced release after HOLD_MAX grant cycles: define MUX_SCHED_TIMEOUT_EN.
module mux8_rr_scheduler
  import mux8_rr_scheduler_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic               s2,
  output logic               s1,
  output logic               s0,
  output logic               busy,
  output logic               timeout
);

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_last;
  logic [SEL_W-1:0]   w_idx;
  logic               w_any;
  logic               w_release;
  logic               w_to_hit;

  rr_pick8 u_pick (
    .req  (req),
    .last (r_last),
    .idx  (w_idx),
    .any  (w_any)
  );

  assign w_release = done | ~req[r_last];

`ifdef MUX_SCHED_TIMEOUT_EN
  logic [7:0] r_hold_cnt;
  logic       r_timeout;

  assign w_to_hit = (r_hold_cnt == 8'(HOLD_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= (r_state == GRANT) && w_to_hit && !w_release;
      if (r_state == IDLE && w_any)
        r_hold_cnt <= '0;
      else if (r_state == GRANT)
        r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_hold;
  assign w_unused_hold = (HOLD_MAX != 0);
  assign w_to_hit      = 1'b0;
  assign timeout       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = GRANT;
      GRANT:   if (w_release || w_to_hit) w_state_nxt = TURN;
      TURN:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Select holds through TURN and IDLE so the mux path never glitches between owners.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant <= '0;
      r_sel   <= '0;
      r_last  <= SEL_W'(NUM_REQ - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= sel_onehot(w_idx);
            r_sel   <= w_idx;
            r_last  <= w_idx;
          end
        end
        GRANT:   if (w_state_nxt == TURN) r_grant <= '0;
        default: r_grant <= '0;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == GRANT);
  end

  assign grant        = r_grant;
  assign {s2, s1, s0} = r_sel;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a negedge monitor checks them.
module tb_mux8_rr_scheduler;

  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic       s2, s1, s0, busy, timeout;

  mux8_rr_scheduler #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .s2(s2), .s1(s1), .s0(s0), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] g;
    logic [2:0] sel;
    logic       bsy;
    logic       to;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got grant=%h sel=%0d busy=%b timeout=%b, want grant=%h sel=%0d busy=%b timeout=%b",
               name, act[12:5], act[4:2], act[1], act[0], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, {grant, s2, s1, s0, busy, timeout}, {e.g, e.sel, e.bsy, e.to});
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the following edge.
  task automatic step(input string name, input logic [7:0] r, input logic d,
                      input logic [7:0] g, input logic [2:0] sel, input logic b, input logic to);
    @(negedge clk);
    #1;
    req  = r;
    done = d;
    q.push_back('{name, g, sel, b, to});
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #1;
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    #1;
    chk(name, {grant, s2, s1, s0, busy, timeout}, 13'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] oh;
    #3;
    chk("reset_state", {grant, s2, s1, s0, busy, timeout}, 13'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Single requester grant and release
    step("g0_grant", 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    step("g0_done",  8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    step("g0_turn",  8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    step("idle_done",8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

    // Full rotation with all requests high
    do_reset("reset_pre_rot");
    for (int k = 0; k <= 8; k++) begin
      oh = 8'h01 << (k % 8);
      step($sformatf("rot%0d_grant", k), 8'hFF, 1'b0, oh,    3'(k % 8), 1'b1, 1'b0);
      step($sformatf("rot%0d_turn",  k), 8'hFF, 1'b1, 8'h00, 3'(k % 8), 1'b0, 1'b0);
      step($sformatf("rot%0d_idle",  k), 8'hFF, 1'b0, 8'h00, 3'(k % 8), 1'b0, 1'b0);
    end

    // No preemption, then wrap search from 4
    step("own3_grant", 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      step($sformatf("own3_hold%0d", k), 8'h88, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
    step("own3_done", 8'h88, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0);
    step("own3_turn", 8'h88, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0);
    step("wrap_to7",  8'h88, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);

    // Owner drops its request without done
    step("drop_rel",  8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0);
    step("drop_turn", 8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0);

    // Reset mid-grant, then requester 0 is favoured over 7
    step("own5_grant", 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
    do_reset("reset_mid_grant");
    step("post_rst_fav0", 8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
    step("post_rst_done", 8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    step("post_rst_turn", 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Long hold: forced release when the timeout is built in, indefinite otherwise
    step("hold_grant", 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
`ifdef MUX_SCHED_TIMEOUT_EN
    for (int k = 1; k < HM; k++)
      step($sformatf("hold_cyc%0d", k), 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    step("to_pulse",  8'h04, 1'b0, 8'h00, 3'd2, 1'b0, 1'b1);
    step("to_turn",   8'h04, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0);
    step("to_regrant",8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
`else
    for (int k = 1; k < 20; k++)
      step($sformatf("hold_cyc%0d", k), 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
`endif
    step("hold_done", 8'h04, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);
    step("hold_turn", 8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
